pipe_skid_buffer: RTL and testbench

Two-entry skid buffer that sits between two pipeline stages of the processor and carries one N-bit payload per cycle under a valid/ready handshake. It is the consumer-facing counterpart of the plain load-enabled stage register: instead of the upstream stage pushing a `load` strobe, the downstream stage pulls data by asserting `out_ready`, and back-pressure propagates upstream through a registered `in_ready`. It gives full throughput with no combinational path from `out_ready` to `in_ready`.

---
 rtl/pipe_skid_buffer.sv | 77 +++++++
 tb/tb_pipe_skid_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready skid buffer with registered in_ready; optional synchronous flush when SKID_BUF_FLUSH_EN is defined
module pipe_skid_buffer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SKID_BUF_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   level
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t       r_state, w_next;
    logic [N-1:0] r_main, r_skid;
    logic         w_accept, w_take, w_flush;
    logic         w_load_main, w_load_skid, w_shift;
`ifdef SKID_BUF_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif
    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign level     = r_state;
    assign out_data  = r_main;
    assign w_accept  = in_valid & in_ready;
    assign w_take    = out_valid & out_ready;
    // next state and data-register load selects; flush overrides any handshake
    always_comb begin
        w_next      = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_shift     = 1'b0;
        if (w_flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_load_main = w_accept;
                    w_next      = w_accept ? ONE : EMPTY;
                end
                ONE: begin
                    w_load_main = w_accept & w_take;
                    w_load_skid = w_accept & ~w_take;
                    w_next      = (w_accept & ~w_take) ? TWO : (~w_accept & w_take) ? EMPTY : ONE;
                end
                TWO: begin
                    w_shift = w_take;
                    w_next  = w_take ? ONE : TWO;
                end
                default: w_next = EMPTY;
            endcase
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= EMPTY;
        else      r_state <= w_next;
    end
    // payload registers: main feeds the output, skid absorbs the in-flight beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) r_main <= in_data;
            else if (w_shift) r_main <= r_skid;
            if (w_load_skid) r_skid <= in_data;
        end
    end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: randomized and directed checks of pipe_skid_buffer against a queue-based FIFO model
module tb_pipe_skid_buffer;
    localparam int N = 32;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic [1:0]   level;
`ifdef SKID_BUF_FLUSH_EN
    logic         flush = 1'b0;
`endif
    int checks = 0;
    int failures = 0;
    logic [N-1:0] q[$];

    pipe_skid_buffer #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SKID_BUF_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("level", {30'd0, level}, 32'(q.size()));
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) check("out_data", out_data, q[0]);
    endtask

    task automatic step(input logic iv, input logic [N-1:0] id, input logic ordy);
        logic acc, tk;
        check_model();
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        acc = iv && (q.size() < 2);
        tk  = ordy && (q.size() > 0);
        @(posedge clk);
        if (tk) void'(q.pop_front());
        if (acc) q.push_back(id);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_level", {30'd0, level}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'hAAAA0001, 1'b0);
        step(1'b1, 32'hAAAA0002, 1'b0);
        step(1'b1, 32'hAAAA0003, 1'b0);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_data", out_data, 32'hAAAA0001);
        step(1'b1, 32'hAAAA0003, 1'b1);
        check("bp_second", out_data, 32'hAAAA0002);
        step(1'b1, 32'hAAAA0003, 1'b1);
        check("bp_third", out_data, 32'hAAAA0003);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 10000; i++) step(1'($urandom), $urandom, 1'($urandom));
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
`ifdef SKID_BUF_FLUSH_EN
        step(1'b1, 32'h11110001, 1'b0);
        step(1'b1, 32'h11110002, 1'b0);
        check_model();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h11110003; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q.delete();
        check("flush_level", {30'd0, level}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step(1'b0, '0, 1'b0);
`endif
        step(1'b1, 32'h55550001, 1'b0);
        step(1'b1, 32'h55550002, 1'b0);
        check("pre_rst_level", {30'd0, level}, 32'd2);
        #2 rst = 1'b0;
        #1;
        q.delete();
        check("arst_level", {30'd0, level}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h77770001, 1'b1);
        step(1'b1, 32'h77770002, 1'b1);
        step(1'b0, '0, 1'b1);
        check_model();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
